// File: rtl/conv_controller_if.sv
// Stream, datapath-strobe and result signals shared by conv_controller and its neighbours.
// Latency: none (signal bundle only).
// Backpressure: s_valid/s_ready on the pixel stream, res_valid/res_ready on the result stream.
//
// Modports:
//   master - the controller's view: consumes the pixel stream and res_ready, drives the
//            datapath strobes and the result stream.
//   slave  - the environment's view (pixel source, convolution datapath, result sink).
interface conv_controller_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int CONV_OUTPUT = 32
);
    // pixel / kernel stream, one column of three rows per beat
    logic                   s_valid;
    logic                   s_ready;
    logic [DATA_WIDTH-1:0]  s_data0;
    logic [DATA_WIDTH-1:0]  s_data1;
    logic [DATA_WIDTH-1:0]  s_data2;

    // convolution datapath control
    logic [DATA_WIDTH-1:0]  conv_data0;
    logic [DATA_WIDTH-1:0]  conv_data1;
    logic [DATA_WIDTH-1:0]  conv_data2;
    logic                   conv_kernel_load;
    logic                   conv_valid_in;
    logic                   conv_valid_out;
    logic [CONV_OUTPUT-1:0] conv_result;

    // result stream
    logic                   res_valid;
    logic                   res_ready;
    logic [CONV_OUTPUT-1:0] res_data;
    logic                   res_last;

    modport master (
        input  s_valid, s_data0, s_data1, s_data2, conv_result, res_ready,
        output s_ready, conv_data0, conv_data1, conv_data2,
               conv_kernel_load, conv_valid_in, conv_valid_out,
               res_valid, res_data, res_last
    );

    modport slave (
        output s_valid, s_data0, s_data1, s_data2, conv_result, res_ready,
        input  s_ready, conv_data0, conv_data1, conv_data2,
               conv_kernel_load, conv_valid_in, conv_valid_out,
               res_valid, res_data, res_last
    );
endinterface

// File: rtl/conv_controller.sv
// Sequences one band of a sliding-window convolution: kernel load, window fill, then one result per column.
// Latency: conv_valid_out 1 cycle after the window-completing beat, res_valid 2 cycles after it; >= 3 cycles/output.
// Backpressure: while res_ready=0 the result holds stable and s_ready stays 0; s_valid=0 freezes the FSM.
//
// Ports:
//   clk, rst     - single clock, asynchronous active-high reset
//   start        - begin a band (honoured in IDLE only)
//   busy, done   - busy outside IDLE; done is a one-cycle pulse at band end
//   bus (master) - pixel stream in, datapath strobes out, conv_result in, result stream out
module conv_controller #(
    parameter int DATA_WIDTH  = 16,
    parameter int KERNEL_SIZE = 3,
    parameter int IMG_WIDTH   = 32,
    parameter int CONV_OUTPUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    conv_controller_if.master bus
);
    localparam int NUM_OUT = IMG_WIDTH - KERNEL_SIZE + 1;
    localparam int BEAT_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
    localparam int OUT_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    if (IMG_WIDTH < KERNEL_SIZE) begin : g_bad_img_width
        $error("conv_controller: IMG_WIDTH must be >= KERNEL_SIZE");
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("conv_controller: DATA_WIDTH must be >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD_K,
        FILL,
        LATCH,
        OUT,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [OUT_W-1:0]   out_cnt;

    logic s_rdy;
    logic accept;
    logic kernel_load;
    logic valid_out;
    logic res_vld;
    logic beat_last;
    logic out_last;

    assign beat_last = (beat_cnt == BEAT_W'(KERNEL_SIZE - 1));
    assign out_last  = (out_cnt == OUT_W'(NUM_OUT - 1));
    assign accept    = bus.s_valid & s_rdy;

    always_comb begin
        next_state  = state;
        s_rdy       = 1'b0;
        kernel_load = 1'b0;
        valid_out   = 1'b0;
        res_vld     = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) next_state = LOAD_K;
            end
            LOAD_K: begin
                s_rdy       = 1'b1;
                kernel_load = bus.s_valid;
                if (bus.s_valid && beat_last) next_state = FILL;
            end
            FILL: begin
                s_rdy = 1'b1;
                if (bus.s_valid && beat_last) next_state = LATCH;
            end
            LATCH: begin
                valid_out  = 1'b1;
                next_state = OUT;
            end
            OUT: begin
                res_vld = 1'b1;
                if (bus.res_ready) next_state = out_last ? DONE : SHIFT;
            end
            SHIFT: begin
                // one new column slides the window by one
                s_rdy = 1'b1;
                if (bus.s_valid) next_state = LATCH;
            end
            DONE: begin
                // start is not looked at here, so a start coincident with done is dropped
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                beat_cnt <= '0;
                out_cnt  <= '0;
            end else begin
                // the beat counter is shared by LOAD_K and FILL and rewinds at each phase end
                if (accept && (state == LOAD_K || state == FILL))
                    beat_cnt <= beat_last ? '0 : beat_cnt + BEAT_W'(1);
                if (state == OUT && bus.res_ready)
                    out_cnt <= out_cnt + OUT_W'(1);
            end
        end
    end

    assign busy                 = (state != IDLE);
    assign bus.s_ready          = s_rdy;
    assign bus.conv_data0       = bus.s_data0;
    assign bus.conv_data1       = bus.s_data1;
    assign bus.conv_data2       = bus.s_data2;
    assign bus.conv_valid_in    = accept;
    assign bus.conv_kernel_load = kernel_load;
    assign bus.conv_valid_out   = valid_out;
    assign bus.res_valid        = res_vld;
    assign bus.res_last         = res_vld & out_last;
    // conv_result is registered in the datapath and only changes on conv_valid_out, so it is stable through OUT
    assign bus.res_data         = res_vld ? bus.conv_result : {CONV_OUTPUT{1'b0}};
endmodule

// File: tb/tb_conv_controller.sv
// Directed + randomized bench for conv_controller with a behavioural datapath stub and a reference model.
// Latency: n/a.
// Backpressure: exercised through res_ready holds and random s_valid stalls.
module tb_conv_controller;
    localparam int DW   = 16;
    localparam int KS   = 3;
    localparam int IW   = 32;
    localparam int CW   = 32;
    localparam int NOUT = IW - KS + 1;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;

    conv_controller_if #(.DATA_WIDTH(DW), .CONV_OUTPUT(CW)) bus ();

    conv_controller #(
        .DATA_WIDTH(DW), .KERNEL_SIZE(KS), .IMG_WIDTH(IW), .CONV_OUTPUT(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .bus(bus)
    );

    always #5 clk = ~clk;

    // stimulus tables: kern[column][row], img[column][row]
    logic [DW-1:0] kern [KS][KS];
    logic [DW-1:0] img  [IW][KS];

    // behavioural datapath stub: column shift registers, registered dot product on conv_valid_out
    logic [DW-1:0] kreg [KS][KS];
    logic [DW-1:0] wreg [KS][KS];

    function automatic logic [CW-1:0] dot();
        logic [CW-1:0] s = '0;
        for (int c = 0; c < KS; c++)
            for (int r = 0; r < KS; r++)
                s += CW'(kreg[c][r]) * CW'(wreg[c][r]);
        return s;
    endfunction

    always @(posedge clk) begin
        if (bus.conv_valid_in) begin
            if (bus.conv_kernel_load) begin
                kreg[0] <= kreg[1];
                kreg[1] <= kreg[2];
                kreg[2] <= '{bus.conv_data0, bus.conv_data1, bus.conv_data2};
            end else begin
                wreg[0] <= wreg[1];
                wreg[1] <= wreg[2];
                wreg[2] <= '{bus.conv_data0, bus.conv_data1, bus.conv_data2};
            end
        end
        if (bus.conv_valid_out) bus.conv_result <= dot();
    end

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // protocol checker: strobes exclusive, conv_valid_out never longer than one cycle
    logic vout_prev = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("vin_and_vout", {31'd0, bus.conv_valid_in & bus.conv_valid_out}, 0);
            chk("vout_one_cycle", {31'd0, vout_prev & bus.conv_valid_out}, 0);
        end
        vout_prev = bus.conv_valid_out;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        #1;
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_kload"}, bus.conv_kernel_load, 0);
        chk({tag, "_vout"}, bus.conv_valid_out, 0);
        chk({tag, "_vin"}, bus.conv_valid_in, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_res_last"}, bus.res_last, 0);
        chk({tag, "_res_data"}, bus.res_data, 0);
    endtask

    // offers one beat, optionally after random idle cycles; returns one step after the accepting edge
    task automatic send_beat(input string tag, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                             input logic [DW-1:0] d2, input bit kl, input bit stall);
        int n = 0;
        while (stall && $urandom_range(0, 1) == 1 && n < 8) begin
            bus.s_valid = 1'b0;
            #1;
            chk({tag, "_stall_vin"}, bus.conv_valid_in, 0);
            chk({tag, "_stall_rdy"}, bus.s_ready, 1);
            step();
            n++;
        end
        bus.s_valid = 1'b1;
        bus.s_data0 = d0;
        bus.s_data1 = d1;
        bus.s_data2 = d2;
        #1;
        chk({tag, "_rdy"}, bus.s_ready, 1);
        chk({tag, "_vin"}, bus.conv_valid_in, 1);
        chk({tag, "_kload"}, bus.conv_kernel_load, kl);
        chk({tag, "_pass1"}, bus.conv_data1, d1);
        step();
        bus.s_valid = 1'b0;
        #1;
    endtask

    // one full band; rst_idx >= 0 aborts with a reset while that output is presented
    task automatic run_band(input string nm, input bit stall, input int bp_idx, input int bp_cycles,
                            input int rst_idx, input bit busy_start);
        logic [CW-1:0] expq [NOUT];
        for (int n = 0; n < NOUT; n++) begin
            expq[n] = '0;
            for (int c = 0; c < KS; c++)
                for (int r = 0; r < KS; r++)
                    expq[n] += CW'(kern[c][r]) * CW'(img[n + c][r]);
        end

        chk({nm, "_idle_busy"}, busy, 0);
        chk({nm, "_idle_rdy"}, bus.s_ready, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        #1;
        chk({nm, "_started_busy"}, busy, 1);

        for (int c = 0; c < KS; c++) begin
            send_beat({nm, "_kbeat"}, kern[c][0], kern[c][1], kern[c][2], 1'b1, stall);
            if (busy_start && c == 0) begin
                start = 1'b1;
                #1;
                chk({nm, "_busy_start_rdy"}, bus.s_ready, 1);
                step();
                start = 1'b0;
                #1;
            end
        end
        for (int c = 0; c < KS; c++)
            send_beat({nm, "_fbeat"}, img[c][0], img[c][1], img[c][2], 1'b0, stall);

        // LATCH: offer a beat that must be refused
        bus.s_valid = 1'b1;
        #1;
        chk({nm, "_latch_vout"}, bus.conv_valid_out, 1);
        chk({nm, "_latch_rdy"}, bus.s_ready, 0);
        step();
        bus.s_valid = 1'b0;
        #1;

        for (int n = 0; n < NOUT; n++) begin
            chk({nm, "_res_valid"}, bus.res_valid, 1);
            chk({nm, "_res_data"}, bus.res_data, expq[n]);
            chk({nm, "_res_last"}, bus.res_last, (n == NOUT - 1) ? 1 : 0);
            chk({nm, "_out_rdy"}, bus.s_ready, 0);
            if (n == rst_idx) begin
                rst = 1'b1;
                bus.s_valid = 1'b1;
                chk_zero({nm, "_midrst"});
                step();
                step();
                chk_zero({nm, "_midrst_hold"});
                rst = 1'b0;
                bus.s_valid = 1'b0;
                step();
                return;
            end
            if (n == bp_idx) begin
                bus.res_ready = 1'b0;
                bus.s_valid = 1'b1;
                for (int k = 0; k < bp_cycles; k++) begin
                    step();
                    chk({nm, "_bp_valid"}, bus.res_valid, 1);
                    chk({nm, "_bp_data"}, bus.res_data, expq[n]);
                    chk({nm, "_bp_last"}, bus.res_last, (n == NOUT - 1) ? 1 : 0);
                    chk({nm, "_bp_rdy"}, bus.s_ready, 0);
                    chk({nm, "_bp_strobe"}, {30'd0, bus.conv_valid_in, bus.conv_valid_out}, 0);
                end
                bus.s_valid = 1'b0;
                bus.res_ready = 1'b1;
                #1;
            end
            step();
            if (n < NOUT - 1) begin
                chk({nm, "_shift_rdy"}, bus.s_ready, 1);
                chk({nm, "_shift_resv"}, bus.res_valid, 0);
                send_beat({nm, "_sbeat"}, img[n + KS][0], img[n + KS][1], img[n + KS][2], 1'b0, stall);
                chk({nm, "_lat_vout"}, bus.conv_valid_out, 1);
                step();
            end else begin
                chk({nm, "_done"}, done, 1);
                chk({nm, "_done_busy"}, busy, 1);
                start = 1'b1;
                step();
                start = 1'b0;
                #1;
                chk({nm, "_done_pulse"}, done, 0);
                chk({nm, "_end_busy"}, busy, 0);
                step();
                chk({nm, "_start_ignored"}, busy, 0);
                chk({nm, "_end_rdy"}, bus.s_ready, 0);
            end
        end
    endtask

    task automatic set_ones();
        for (int c = 0; c < KS; c++)
            for (int r = 0; r < KS; r++) kern[c][r] = DW'(1);
        for (int c = 0; c < IW; c++)
            for (int r = 0; r < KS; r++) img[c][r] = DW'(1);
    endtask

    task automatic set_center();
        for (int c = 0; c < KS; c++)
            for (int r = 0; r < KS; r++) kern[c][r] = (c == 1 && r == 1) ? DW'(1) : DW'(0);
        for (int c = 0; c < IW; c++)
            for (int r = 0; r < KS; r++) img[c][r] = DW'(c);
    endtask

    task automatic set_random();
        for (int c = 0; c < KS; c++)
            for (int r = 0; r < KS; r++) kern[c][r] = DW'($urandom_range(0, 255));
        for (int c = 0; c < IW; c++)
            for (int r = 0; r < KS; r++) img[c][r] = DW'($urandom_range(0, 255));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data0 = '0;
        bus.s_data1 = '0;
        bus.s_data2 = '0;
        bus.res_ready = 1'b1;
        chk_zero("por");
        step();
        step();
        bus.s_valid = 1'b0;
        rst = 1'b0;
        step();

        set_ones();
        run_band("ones", 1'b0, -1, 0, -1, 1'b1);
        set_center();
        run_band("center_bp", 1'b0, 3, 5, -1, 1'b0);
        set_ones();
        run_band("ones_stall", 1'b1, -1, 0, -1, 1'b0);
        set_ones();
        run_band("ones_rst", 1'b0, -1, 0, 9, 1'b0);
        set_center();
        run_band("center_after_rst", 1'b0, -1, 0, -1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_random();
            run_band("random", 1'b1, $urandom_range(0, NOUT - 1), $urandom_range(1, 6), -1, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
